// File: rtl/jtdsp16_pcu.sv
// Program control unit: PC sequencing, a circular return stack, nested
// zero-overhead do-loops and single-level interrupt entry/return.
module jtdsp16_pcu #(
  parameter int AW      = 16,
  parameter int SDEPTH  = 4,
  parameter int LDEPTH  = 2,
  parameter int CW      = 7,
  parameter int IRQ_VEC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          halt,
  input  logic          go,
  input  logic          call,
  input  logic          ret,
  input  logic          iret,
  input  logic [AW-1:0] target,
  input  logic          do_start,
  input  logic [3:0]    do_len,
  input  logic [CW-1:0] do_cnt,
  input  logic          irq,
  input  logic          no_int,
  output logic [AW-1:0] rom_addr,
  output logic [AW-1:0] pi,
  output logic          iack,
  output logic          in_irq,
  output logic          do_active,
  output logic          stk_ovf,
  output logic          stk_udf,
  output logic          loop_ovf
);
  localparam int SPW = $clog2(SDEPTH);
  localparam int SCW = $clog2(SDEPTH + 1);
  localparam int LCW = $clog2(LDEPTH + 1);

  logic [AW-1:0]  pc_r, pi_r;
  logic           in_irq_r, iack_r;
  logic [AW-1:0]  stk_r [SDEPTH];
  logic [SPW-1:0] sp_r;
  logic [SCW-1:0] scnt_r;
  logic [AW-1:0]  lhead_r [LDEPTH];
  logic [AW-1:0]  lend_r  [LDEPTH];
  logic [CW-1:0]  lleft_r [LDEPTH];
  logic [LCW-1:0] lcnt_r;
  logic           stk_ovf_r, stk_udf_r, loop_ovf_r;

  logic [AW-1:0]  pc_inc_s, len_s, pc_nx_s, pi_nx_s;
  logic [AW-1:0]  top_head_s, top_end_s;
  logic [CW-1:0]  top_left_s;
  logic [LCW-1:0] ltop_s;
  logic           do_active_s, lend_hit_s, irq_ok_s, in_irq_nx_s;
  logic           push_s, pop_s, udf_s, lpush_s, lpop_s, ldec_s, lovf_s;

  assign pc_inc_s    = pc_r + {{(AW-1){1'b0}}, 1'b1};
  assign len_s       = (do_len == 4'd0) ? {{(AW-1){1'b0}}, 1'b1} : AW'(do_len);
  assign do_active_s = (lcnt_r != {LCW{1'b0}});
  assign ltop_s      = lcnt_r - {{(LCW-1){1'b0}}, 1'b1};
  assign lend_hit_s  = do_active_s && (pc_r == top_end_s);
  assign irq_ok_s    = irq && !in_irq_r && !no_int && !halt && !do_active_s &&
                       !(call || go || ret || iret || do_start);

  // Select the top loop-stack entry without an out-of-range index when empty
  always_comb begin
    top_head_s = {AW{1'b0}};
    top_end_s  = {AW{1'b0}};
    top_left_s = {CW{1'b0}};
    for (int i = 0; i < LDEPTH; i++) begin
      if (LCW'(i) == ltop_s) begin
        top_head_s = lhead_r[i];
        top_end_s  = lend_r[i];
        top_left_s = lleft_r[i];
      end else begin
        top_head_s = top_head_s;
      end
    end
  end

  // Next-PC priority resolution and stack operation decode
  always_comb begin
    pc_nx_s     = pc_r;
    pi_nx_s     = pi_r;
    in_irq_nx_s = in_irq_r;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    udf_s   = 1'b0;
    lpush_s = 1'b0;
    lpop_s  = 1'b0;
    ldec_s  = 1'b0;
    lovf_s  = 1'b0;
    if (halt) begin
      pc_nx_s = pc_r;
    end else if (irq_ok_s) begin
      pi_nx_s     = pc_inc_s;
      pc_nx_s     = AW'(IRQ_VEC);
      in_irq_nx_s = 1'b1;
    end else if (call) begin
      push_s  = 1'b1;
      pc_nx_s = target;
    end else if (go) begin
      pc_nx_s = target;
    end else if (ret) begin
      if (scnt_r != {SCW{1'b0}}) begin
        pop_s   = 1'b1;
        pc_nx_s = stk_r[sp_r - {{(SPW-1){1'b0}}, 1'b1}];
      end else begin
        udf_s   = 1'b1;
        pc_nx_s = pc_inc_s;
      end
    end else if (iret) begin
      pc_nx_s     = pi_r;
      in_irq_nx_s = 1'b0;
    end else if (lend_hit_s) begin
      if (top_left_s > {{(CW-1){1'b0}}, 1'b1}) begin
        ldec_s  = 1'b1;
        pc_nx_s = top_head_s;
      end else begin
        lpop_s  = 1'b1;
        pc_nx_s = top_end_s + {{(AW-1){1'b0}}, 1'b1};
      end
    end else if (do_start) begin
      if (do_cnt == {CW{1'b0}}) begin
        pc_nx_s = pc_inc_s + len_s;
      end else if (lcnt_r == LCW'(LDEPTH)) begin
        lovf_s  = 1'b1;
        pc_nx_s = pc_inc_s;
      end else begin
        lpush_s = 1'b1;
        pc_nx_s = pc_inc_s;
      end
    end else begin
      pc_nx_s = pc_inc_s;
    end
  end

  // State registers; the return stack overwrites its oldest entry when full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= {AW{1'b0}};
      pi_r       <= {AW{1'b0}};
      in_irq_r   <= 1'b0;
      iack_r     <= 1'b0;
      sp_r       <= {SPW{1'b0}};
      scnt_r     <= {SCW{1'b0}};
      lcnt_r     <= {LCW{1'b0}};
      stk_ovf_r  <= 1'b0;
      stk_udf_r  <= 1'b0;
      loop_ovf_r <= 1'b0;
      for (int i = 0; i < SDEPTH; i++) stk_r[i] <= {AW{1'b0}};
      for (int i = 0; i < LDEPTH; i++) begin
        lhead_r[i] <= {AW{1'b0}};
        lend_r[i]  <= {AW{1'b0}};
        lleft_r[i] <= {CW{1'b0}};
      end
    end else if (cen) begin
      pc_r     <= pc_nx_s;
      pi_r     <= pi_nx_s;
      in_irq_r <= in_irq_nx_s;
      iack_r   <= irq_ok_s;
      if (push_s) begin
        stk_r[sp_r] <= pc_inc_s;
        sp_r        <= sp_r + {{(SPW-1){1'b0}}, 1'b1};
        if (scnt_r == SCW'(SDEPTH)) stk_ovf_r <= 1'b1;
        else scnt_r <= scnt_r + {{(SCW-1){1'b0}}, 1'b1};
      end else if (pop_s) begin
        sp_r   <= sp_r - {{(SPW-1){1'b0}}, 1'b1};
        scnt_r <= scnt_r - {{(SCW-1){1'b0}}, 1'b1};
      end
      if (udf_s) stk_udf_r <= 1'b1;
      if (lovf_s) loop_ovf_r <= 1'b1;
      if (lpush_s) begin
        for (int i = 0; i < LDEPTH; i++) begin
          if (LCW'(i) == lcnt_r) begin
            lhead_r[i] <= pc_inc_s;
            lend_r[i]  <= pc_r + len_s;
            lleft_r[i] <= do_cnt;
          end
        end
        lcnt_r <= lcnt_r + {{(LCW-1){1'b0}}, 1'b1};
      end else if (ldec_s) begin
        for (int i = 0; i < LDEPTH; i++) begin
          if (LCW'(i) == ltop_s) lleft_r[i] <= lleft_r[i] - {{(CW-1){1'b0}}, 1'b1};
        end
      end else if (lpop_s) begin
        lcnt_r <= ltop_s;
      end
    end
  end

  assign rom_addr  = pc_r;
  assign pi        = pi_r;
  assign iack      = iack_r;
  assign in_irq    = in_irq_r;
  assign do_active = do_active_s;
  assign stk_ovf   = stk_ovf_r;
  assign stk_udf   = stk_udf_r;
  assign loop_ovf  = loop_ovf_r;
endmodule

// File: tb/tb_jtdsp16_pcu.sv
// Directed bench for jtdsp16_pcu: reset, wrap, call/ret depth, loops,
// nesting, interrupts, halt/cen freeze and reset mid-loop.
module tb_jtdsp16_pcu;
  logic        clk, rst_n, cen, halt, go, call, ret, iret, do_start, irq, no_int;
  logic [15:0] target, rom_addr, pi;
  logic [3:0]  do_len;
  logic [6:0]  do_cnt;
  logic        iack, in_irq, do_active, stk_ovf, stk_udf, loop_ovf;
  int          total = 0;
  int          bad = 0;
  int          inner = 0;
  logic [15:0] loop_exp [6] = '{16'h0012, 16'h0013, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
  logic [15:0] nest_exp [12] = '{16'h0022, 16'h0022, 16'h0022, 16'h0023, 16'h0024, 16'h0021,
                                 16'h0022, 16'h0022, 16'h0022, 16'h0023, 16'h0024, 16'h0025};

  jtdsp16_pcu dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .halt(halt), .go(go), .call(call),
    .ret(ret), .iret(iret), .target(target), .do_start(do_start), .do_len(do_len),
    .do_cnt(do_cnt), .irq(irq), .no_int(no_int), .rom_addr(rom_addr), .pi(pi),
    .iack(iack), .in_irq(in_irq), .do_active(do_active), .stk_ovf(stk_ovf),
    .stk_udf(stk_udf), .loop_ovf(loop_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; halt = 1'b0; go = 1'b0; call = 1'b0; ret = 1'b0;
    iret = 1'b0; do_start = 1'b0; irq = 1'b0; no_int = 1'b0;
    target = 16'h0000; do_len = 4'd0; do_cnt = 7'd0;
    tick();
    chk("rst_pc", rom_addr, 16'h0000);
    chk("rst_pi", pi, 16'h0000);
    chk("rst_iack", iack, 1'b0);
    chk("rst_inirq", in_irq, 1'b0);
    chk("rst_doact", do_active, 1'b0);
    chk("rst_sticky", {stk_ovf, stk_udf, loop_ovf}, 3'b000);
    rst_n = 1'b1; cen = 1'b1;
    tick(); chk("inc", rom_addr, 16'h0001);

    // five nested calls into a four-deep stack
    call = 1'b1;
    target = 16'h0100; tick(); chk("call1", rom_addr, 16'h0100);
    target = 16'h0200; tick(); chk("call2", rom_addr, 16'h0200);
    target = 16'h0300; tick(); chk("call3", rom_addr, 16'h0300);
    target = 16'h0400; tick(); chk("call4", rom_addr, 16'h0400);
    chk("ovf_early", stk_ovf, 1'b0);
    target = 16'h0500; tick(); chk("call5", rom_addr, 16'h0500);
    chk("stk_ovf", stk_ovf, 1'b1);
    call = 1'b0; ret = 1'b1;
    tick(); chk("ret1", rom_addr, 16'h0401);
    tick(); chk("ret2", rom_addr, 16'h0301);
    tick(); chk("ret3", rom_addr, 16'h0201);
    tick(); chk("ret4", rom_addr, 16'h0101);
    chk("udf_early", stk_udf, 1'b0);
    tick(); chk("ret5", rom_addr, 16'h0102);
    chk("stk_udf", stk_udf, 1'b1);
    ret = 1'b0;

    go = 1'b1; target = 16'hFFFE; tick(); chk("go_fffe", rom_addr, 16'hFFFE);
    go = 1'b0;
    tick(); chk("wrap0", rom_addr, 16'hFFFF);
    tick(); chk("wrap1", rom_addr, 16'h0000);
    tick(); chk("wrap2", rom_addr, 16'h0001);

    // loop with irq pending: entry deferred until the loop drains
    go = 1'b1; target = 16'h0010; tick(); go = 1'b0;
    do_start = 1'b1; do_len = 4'd3; do_cnt = 7'd2; irq = 1'b1;
    tick(); chk("loop_h", rom_addr, 16'h0011);
    chk("loop_act", do_active, 1'b1);
    do_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("loop_tr", rom_addr, loop_exp[i]);
      chk("loop_noack", iack, 1'b0);
    end
    chk("loop_done", do_active, 1'b0);
    tick();
    chk("irq_pc", rom_addr, 16'h0001);
    chk("irq_ack", iack, 1'b1);
    chk("irq_pi", pi, 16'h0015);
    chk("irq_in", in_irq, 1'b1);
    irq = 1'b0;
    tick(); chk("irq_pc2", rom_addr, 16'h0002);
    chk("irq_ack0", iack, 1'b0);
    iret = 1'b1; tick(); iret = 1'b0;
    chk("iret_pc", rom_addr, 16'h0015);
    chk("iret_in", in_irq, 1'b0);

    // nested loops: outer 0x21..0x24 x2, inner 0x22 x3
    go = 1'b1; target = 16'h0020; tick(); go = 1'b0;
    do_start = 1'b1; do_len = 4'd4; do_cnt = 7'd2;
    tick(); chk("nest_h", rom_addr, 16'h0021);
    for (int i = 0; i < 12; i++) begin
      do_start = (rom_addr == 16'h0021);
      do_len = 4'd1; do_cnt = 7'd3;
      tick();
      do_start = 1'b0;
      chk("nest_tr", rom_addr, nest_exp[i]);
      if (rom_addr == 16'h0022) inner++;
    end
    chk("nest_inner", inner, 6);
    chk("nest_done", do_active, 1'b0);

    // zero count skips the body; zero length behaves as length one
    do_start = 1'b1; do_len = 4'd3; do_cnt = 7'd0;
    tick(); chk("skip_pc", rom_addr, 16'h0029);
    chk("skip_act", do_active, 1'b0);
    do_len = 4'd0; do_cnt = 7'd1;
    tick(); chk("len0_pc", rom_addr, 16'h002A);
    chk("len0_act", do_active, 1'b1);
    do_start = 1'b0;
    tick(); chk("len0_exit", rom_addr, 16'h002B);
    chk("len0_done", do_active, 1'b0);

    // third nested do_start overflows the two-entry loop stack
    go = 1'b1; target = 16'h0030; tick(); go = 1'b0;
    do_start = 1'b1; do_cnt = 7'd1;
    do_len = 4'd5; tick(); chk("lo_a", rom_addr, 16'h0031);
    do_len = 4'd3; tick(); chk("lo_b", rom_addr, 16'h0032);
    chk("lovf_early", loop_ovf, 1'b0);
    do_len = 4'd1; tick(); chk("lo_c", rom_addr, 16'h0033);
    chk("loop_ovf", loop_ovf, 1'b1);
    do_start = 1'b0;
    tick(); chk("lo_t1", rom_addr, 16'h0034);
    tick(); chk("lo_t2", rom_addr, 16'h0035);
    tick(); chk("lo_t3", rom_addr, 16'h0036);
    chk("lo_done", do_active, 1'b0);

    // a jump at the loop end wins and leaves the loop count untouched
    go = 1'b1; target = 16'h0040; tick(); go = 1'b0;
    do_start = 1'b1; do_len = 4'd2; do_cnt = 7'd2; tick(); do_start = 1'b0;
    tick(); chk("pr_end", rom_addr, 16'h0042);
    go = 1'b1; target = 16'h0050; tick(); chk("pr_go", rom_addr, 16'h0050);
    chk("pr_act", do_active, 1'b1);
    target = 16'h0042; tick(); go = 1'b0; chk("pr_back", rom_addr, 16'h0042);
    tick(); chk("pr_t1", rom_addr, 16'h0041);
    tick(); chk("pr_t2", rom_addr, 16'h0042);
    tick(); chk("pr_t3", rom_addr, 16'h0043);
    chk("pr_done", do_active, 1'b0);

    // halt and cen low at the loop end freeze everything
    go = 1'b1; target = 16'h0010; tick(); go = 1'b0;
    do_start = 1'b1; do_len = 4'd3; do_cnt = 7'd2; tick(); do_start = 1'b0;
    tick(); tick(); chk("hc_end", rom_addr, 16'h0013);
    halt = 1'b1; tick(); halt = 1'b0; chk("hc_halt", rom_addr, 16'h0013);
    cen = 1'b0; tick(); cen = 1'b1; chk("hc_cen", rom_addr, 16'h0013);
    tick(); chk("hc_t1", rom_addr, 16'h0011);
    tick(); chk("hc_t2", rom_addr, 16'h0012);
    tick(); chk("hc_t3", rom_addr, 16'h0013);
    tick(); chk("hc_t4", rom_addr, 16'h0014);
    chk("hc_done", do_active, 1'b0);

    // reset in the middle of a loop
    go = 1'b1; target = 16'h0010; tick(); go = 1'b0;
    do_start = 1'b1; tick(); do_start = 1'b0;
    tick(); chk("mr_pc", rom_addr, 16'h0012);
    rst_n = 1'b0; tick();
    chk("mr_rst_pc", rom_addr, 16'h0000);
    chk("mr_rst_act", do_active, 1'b0);
    chk("mr_rst_sticky", {stk_ovf, stk_udf, loop_ovf}, 3'b000);
    rst_n = 1'b1;

    // no_int blocks entry; a pending irq is taken once it drops
    irq = 1'b1; no_int = 1'b1;
    tick(); chk("ni_pc", rom_addr, 16'h0001);
    chk("ni_ack", iack, 1'b0);
    no_int = 1'b0;
    tick(); chk("ni_irq_pc", rom_addr, 16'h0001);
    chk("ni_irq_pi", pi, 16'h0002);
    chk("ni_irq_ack", iack, 1'b1);
    tick(); chk("ni_busy_pc", rom_addr, 16'h0002);
    chk("ni_busy_ack", iack, 1'b0);
    irq = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtdsp16_pcu.md
JTDSP16_PCU -- requirements
Module: jtdsp16_pcu

Interface
REQ-001 SHALL have parameter AW, default 16: program address width.
REQ-002 SHALL have parameter SDEPTH, default 4: return-stack entries (power of two, >=2).
REQ-003 SHALL have parameter LDEPTH, default 2: nested do-loop stack entries (>=1).
REQ-004 SHALL have parameter CW, default 7: loop repeat-count width.
REQ-005 SHALL have parameter IRQ_VEC, default 1: interrupt entry address.
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  synchronous active-low reset.
cen  in  1  clock enable; state changes only when high.
halt  in  1  freeze PC this cycle.
go  in  1  jump to target.
call  in  1  push return address, jump to target.
ret  in  1  pop return address into PC.
iret  in  1  return from interrupt.
target  in  AW  jump/call destination.
do_start  in  1  start do-loop at current PC.
do_len  in  4  body length in instructions (1..15).
do_cnt  in  CW  repetitions.
irq  in  1  interrupt request, level.
no_int  in  1  block interrupt entry this cycle.
rom_addr  out  AW  current PC.
pi  out  AW  saved interrupt return address.
iack  out  1  one-cycle pulse on interrupt entry.
in_irq  out  1  servicing interrupt.
do_active  out  1  loop stack non-empty.
stk_ovf  out  1  sticky return-stack overflow.
stk_udf  out  1  sticky return-stack underflow.
loop_ovf  out  1  sticky loop-stack overflow.

Function
REQ-008 SHALL drive rom_addr = pc combinationally; pc increments modulo 2^AW (all-ones wraps to 0).
REQ-009 Next-pc priority, evaluated only when cen=1: halt (pc held, nothing else updates except stickies) > interrupt entry > call > go > ret > iret > loop-end > do_start > pc+1.
REQ-010 call SHALL push pc+1 and set pc=target; when the stack is full, the oldest entry is overwritten (circular) and stk_ovf set.
REQ-011 ret SHALL set pc=top and pop; when empty, pc=pc+1, pointer unchanged, stk_udf set.
REQ-012 Interrupt entry SHALL occur when irq && !in_irq && !no_int && !halt && !do_active && none of call/go/ret/iret/do_start: pi=pc+1, pc=IRQ_VEC, in_irq=1, iack=1 for exactly the next cen cycle.
REQ-013 iret SHALL set pc=pi and in_irq=0; iret with in_irq=0 still jumps to pi.
REQ-014 do_start at pc=P SHALL push {head=P+1, end=P+do_len, left=do_cnt} and set pc=P+1; do_cnt=0 SHALL skip the body (pc=P+do_len+1, nothing pushed).
REQ-015 do_start with a full loop stack SHALL execute the body once, push nothing, and set loop_ovf.
REQ-016 Loop end SHALL be detected when do_active and pc==top.end; if left>1, pc=head and left decrements; if left==1, pop and pc=end+1.
REQ-017 Nested loops sharing an end address SHALL resolve only the top entry per cycle; the outer entry is evaluated on its next end hit.
REQ-018 A call/go/ret/iret at a loop end SHALL take precedence; the loop stack stays unchanged.
REQ-019 do_len=0 SHALL be treated as 1.
REQ-020 Stickies SHALL clear only on reset.

Reset
REQ-021 While rst_n=0 at a clock edge, regardless of cen: pc=0, pi=0, stacks empty, iack=0, in_irq=0, all stickies 0, do_active=0; reset mid-loop or mid-interrupt discards all state.

Verification
REQ-022 Sequential/wrap (AW=16): pc=16'hFFFE, 3 idle cycles -> rom_addr FFFF, 0000, 0001.
REQ-023 Call/ret depth: 5 nested calls with SDEPTH=4 -> stk_ovf=1; 4 rets return correct addresses; 5th ret -> pc+1, stk_udf=1.
REQ-024 Loop: do_start at pc=0x10, do_len=3, do_cnt=2 -> addresses 11,12,13,11,12,13,14; do_active low from the cycle pc=14.
REQ-025 Nested: outer loop (len 4, cnt 2) containing inner loop (len 1, cnt 3) -> exact address trace; inner body issued 6 times total.
REQ-026 Interrupt: irq high during loop -> no iack until loop exits; then pc=1, iack one cycle, pi=exit+1; iret -> pc=pi, in_irq=0.
REQ-027 halt and cen=0 during loop end -> pc and loop count frozen; resumes exact trace; rst_n low mid-loop -> pc=0, do_active=0.
